// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: decoder store-size and load-adjust codes
// plus the controller state type.
package lsu_pkg;

   localparam logic [1:0] SZ_W  = 2'b00;
   localparam logic [1:0] SZ_B  = 2'b01;
   localparam logic [1:0] SZ_H  = 2'b10;

   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_B  = 3'b001;
   localparam logic [2:0] LD_H  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b101;
   localparam logic [2:0] LD_HU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it
// according to the load-adjust code.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  load_adj,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata[{offset, 3'b000} +: 8];
      lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
      // NOTE: every output of a combinational block gets a value on every path
      // (default arm here), otherwise synthesis infers a latch.
      case (load_adj)
         LD_W:    data = rdata;
         LD_B:    data = {{24{lane_b[7]}}, lane_b};
         LD_H:    data = {{16{lane_h[15]}}, lane_h};
         LD_BU:   data = {24'd0, lane_b};
         LD_HU:   data = {16'd0, lane_h};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: validates the decoded access, runs one req/ack transaction to data
// memory with a timeout, and returns the aligned load result while stalling the core.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              mem_we,
   input  logic [1:0]        store_size,
   input  logic [2:0]        load_adj,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              access_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_ack
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   state_t      state, state_nxt;
   logic [7:0]  tmo_cnt;
   logic [2:0]  ld_adj_q;
   logic [1:0]  offset_q;
   logic        req_bad;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] align_data;
   logic        start, reject, complete, abort;

   // Illegal code or misaligned address for the selected access width.
   always_comb begin
      req_bad = 1'b0;
      if (mem_we) begin
         case (store_size)
            SZ_W:    req_bad = (addr[1:0] != 2'b00);
            SZ_B:    req_bad = 1'b0;
            SZ_H:    req_bad = addr[0];
            default: req_bad = 1'b1;
         endcase
      end else begin
         case (load_adj)
            LD_W:          req_bad = (addr[1:0] != 2'b00);
            LD_B, LD_BU:   req_bad = 1'b0;
            LD_H, LD_HU:   req_bad = addr[0];
            default:       req_bad = 1'b1;
         endcase
      end
   end

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = wdata;
      case (store_size)
         SZ_B: begin
            st_be    = 4'b0001 << addr[1:0];
            st_wdata = {4{wdata[7:0]}};
         end
         SZ_H: begin
            st_be    = 4'b0011 << {addr[1], 1'b0};
            st_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   lsu_load_align u_align (
      .rdata    (bus_rdata),
      .offset   (offset_q),
      .load_adj (ld_adj_q),
      .data     (align_data)
   );

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      reject    = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state)
         ST_IDLE: if (req_valid) begin
            if (req_bad) begin
               reject    = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               start     = 1'b1;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus_ack) begin
               complete  = 1'b1;
               state_nxt = ST_DONE;
            end else if (tmo_cnt == TMO_LIMIT) begin
               abort     = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign stall = req_valid && (state != ST_DONE);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tmo_cnt    <= '0;
         ld_adj_q   <= '0;
         offset_q   <= '0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_be     <= '0;
         bus_wdata  <= '0;
         load_data  <= '0;
         access_err <= 1'b0;
      end else begin
         state      <= state_nxt;
         access_err <= reject | abort;
         if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_be    <= mem_we ? st_be : 4'b1111;
            bus_wdata <= mem_we ? st_wdata : 32'd0;
            ld_adj_q  <= load_adj;
            offset_q  <= addr[1:0];
            tmo_cnt   <= '0;
         end else if (state == ST_BUSY && !complete && !abort) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
         if (complete || abort) bus_req <= 1'b0;
         // Stores leave the previous load result untouched.
         if (reject || abort) load_data <= '0;
         else if (complete && !bus_we) load_data <= align_data;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases followed by random accesses,
// all compared against a behavioural model of the access rules.
module tb_lsu_mem_ctrl;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        mem_we;
   logic [1:0]  store_size;
   logic [2:0]  load_adj;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        access_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   int n_tests = 0;
   int n_fail  = 0;

   lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .mem_we     (mem_we),
      .store_size (store_size),
      .load_adj   (load_adj),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .load_data  (load_data),
      .access_err (access_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_ack    (bus_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_legal(input logic we, input logic [1:0] sz,
                                      input logic [2:0] adj, input logic [31:0] a);
      int unsigned ua = a;
      if (we) begin
         case (sz)
            2'd0:    return (ua % 4) == 0;
            2'd1:    return 1'b1;
            2'd2:    return (ua % 2) == 0;
            default: return 1'b0;
         endcase
      end
      case (adj)
         3'd0:       return (ua % 4) == 0;
         3'd1, 3'd5: return 1'b1;
         3'd2, 3'd6: return (ua % 2) == 0;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic we, input logic [1:0] sz,
                                           input logic [31:0] a);
      int unsigned off = a % 4;
      if (!we || sz == 2'd0) return 4'hF;
      if (sz == 2'd1) return 4'(1 << off);
      return 4'(3 << (off / 2 * 2));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd1) return (wd & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd2) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] adj, input logic [31:0] a,
                                              input logic [31:0] rd);
      int unsigned off = a % 4;
      logic [31:0] b, h;
      b = (rd >> (8 * off)) & 32'hFF;
      h = (rd >> (16 * (off / 2))) & 32'hFFFF;
      case (adj)
         3'd0:    return rd;
         3'd1:    return (b >= 128) ? b - 32'd256 : b;
         3'd2:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd5:    return b;
         3'd6:    return h;
         default: return 32'd0;
      endcase
   endfunction

   // One complete access, entered and left at posedge+1 with the DUT in IDLE.
   // ack_dly < 0 means memory never acknowledges.
   task automatic run_op(input string name, input logic we, input logic [1:0] sz,
                         input logic [2:0] adj, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_dly, input bit drop);
      bit legal, timed_out, done, unstable;
      int stalls, busy, exp_busy, exp_stalls;
      legal     = model_legal(we, sz, adj, a);
      timed_out = legal && (ack_dly < 0);
      exp_busy  = (ack_dly < 0) ? TIMEOUT + 1 : ack_dly + 1;
      req_valid = 1'b1; mem_we = we; store_size = sz; load_adj = adj;
      addr = a; wdata = wd;
      #1;
      stalls = stall ? 1 : 0;
      @(posedge clk); #1;
      if (legal) begin
         check({name, ".bus_we"},   bus_we, we);
         check({name, ".bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
         check({name, ".bus_be"},   bus_be, model_be(we, sz, a));
         if (we) check({name, ".bus_wdata"}, bus_wdata, model_wdata(sz, wd));
         busy = 0; done = 0; unstable = 0;
         while (!done && busy < 300) begin
            if (drop && busy == 1) req_valid = 1'b0;
            bus_ack   = (ack_dly >= 0) && (busy == ack_dly);
            bus_rdata = bus_ack ? rd : $urandom;
            #1;
            if (stall) stalls++;
            if (bus_req !== 1'b1 || bus_addr !== (a & 32'hFFFF_FFFC) ||
                bus_be !== model_be(we, sz, a) || bus_we !== we) unstable = 1;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            busy++;
            done = (bus_req == 1'b0);
         end
         check({name, ".bus_stable"}, 32'(unstable), 32'd0);
         check({name, ".busy_cycles"}, busy, exp_busy);
      end else begin
         check({name, ".no_bus_req"}, bus_req, 1'b0);
      end
      // DONE cycle
      check({name, ".done_stall"}, stall, 1'b0);
      check({name, ".access_err"}, access_err, !legal || timed_out);
      check({name, ".done_bus_req"}, bus_req, 1'b0);
      if (!legal || timed_out) check({name, ".load_data_err"}, load_data, 32'd0);
      else if (!we && !drop)   check({name, ".load_data"}, load_data, model_load(adj, a, rd));
      exp_stalls = !legal ? 1 : (drop ? 2 : exp_busy + 1);
      check({name, ".stall_cycles"}, stalls, exp_stalls);
      @(posedge clk); #1;
      check({name, ".err_pulse"}, access_err, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        we, drp;
      logic [1:0]  sz;
      logic [2:0]  adj;
      logic [31:0] a;
      int          dly;

      rst_n = 1'b0; req_valid = 1'b0; mem_we = 1'b0; store_size = '0; load_adj = '0;
      addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
      #1;
      check("rst.bus_req",    bus_req, 1'b0);
      check("rst.bus_we",     bus_we, 1'b0);
      check("rst.bus_be",     bus_be, 4'h0);
      check("rst.bus_addr",   bus_addr, 32'd0);
      check("rst.bus_wdata",  bus_wdata, 32'd0);
      check("rst.load_data",  load_data, 32'd0);
      check("rst.access_err", access_err, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases from the access rules.
      run_op("sw",   1'b1, 2'b00, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0);
      run_op("sb",   1'b1, 2'b01, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 1'b0);
      run_op("sh",   1'b1, 2'b10, 3'd0, 32'h106, 32'h1234BEEF, 32'h0, 1, 1'b0);
      run_op("lb",   1'b0, 2'b00, 3'd1, 32'h102, 32'h0, 32'h0080FF11, 1, 1'b0);
      run_op("lbu",  1'b0, 2'b00, 3'd5, 32'h102, 32'h0, 32'h0080FF11, 0, 1'b0);
      run_op("lh",   1'b0, 2'b00, 3'd2, 32'h102, 32'h0, 32'h80015A5A, 3, 1'b0);
      run_op("lhu",  1'b0, 2'b00, 3'd6, 32'h100, 32'h0, 32'h1234F00D, 0, 1'b0);
      run_op("lw_mis", 1'b0, 2'b00, 3'd0, 32'h102, 32'h0, 32'h0, 0, 1'b0);
      run_op("st_ill", 1'b1, 2'b11, 3'd0, 32'h100, 32'h0, 32'h0, 0, 1'b0);
      run_op("ld_ill", 1'b0, 2'b00, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1'b0);
      run_op("lw_tmo", 1'b0, 2'b00, 3'd0, 32'h200, 32'h0, 32'h0, -1, 1'b0);
      run_op("lw",   1'b0, 2'b00, 3'd0, 32'h204, 32'h0, 32'hCAFEF00D, 0, 1'b0);

      // Stray ack while idle must not start anything.
      req_valid = 1'b0; bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check("idle_ack.bus_req", bus_req, 1'b0);
      check("idle_ack.err", access_err, 1'b0);

      // Reset in the middle of a transaction.
      req_valid = 1'b1; mem_we = 1'b0; load_adj = 3'd0; addr = 32'h300;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst.busy", bus_req, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst.bus_req", bus_req, 1'b0);
      check("mid_rst.stall",   stall, 1'b1);
      check("mid_rst.bus_addr", bus_addr, 32'd0);
      check("mid_rst.bus_be",  bus_be, 4'h0);
      req_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("post_rst", 1'b0, 2'b00, 3'd1, 32'h301, 32'h0, 32'h0000C300, 1, 1'b0);

      // Random accesses.
      for (int i = 0; i < 40; i++) begin
         we  = 1'($urandom);
         sz  = 2'($urandom);
         adj = 3'($urandom);
         a   = $urandom;
         if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
         dly = $urandom_range(4, 0);
         drp = model_legal(we, sz, adj, a) && ($urandom_range(7, 0) == 0);
         run_op("rnd", we, sz, adj, a, $urandom, $urandom, dly, drp);
         if ($urandom_range(3, 0) == 0) begin
            req_valid = 1'b0;
            @(posedge clk); #1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit directly downstream of the control decoder in the single-cycle RISC-V core.
- Consumes the decoder's memory controls: memRW, the store-size code (dataIn) and the load-adjust code (dataOutAddj). Also takes the ALU address and rs2 data.
- Runs a req/ack handshake to data memory, stalling the core until the access completes.
- Returns aligned, sign- or zero-extended load data to the write-back mux.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT, 255, cycles in BUSY without ack before the access is aborted (8-bit counter).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  current instruction is a memory access (load: wb_sel==00; store: memRW==1).
- mem_we  in  1  1=store, 0=load (decoder memRW).
- store_size  in  2  00=word, 01=byte, 10=half, 11=illegal.
- load_adj  in  3  000=LW, 001=LB, 010=LH, 101=LBU, 110=LHU, others illegal.
- addr  in  ADDR_W  byte address from ALU.
- wdata  in  32  rs2 data.
- stall  out  1  core must hold PC and register file.
- load_data  out  32  extended load result, valid in DONE.
- access_err  out  1  misaligned, illegal code or timeout; one-cycle pulse.
- bus_req  out  1  memory request.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  memory read word.
- bus_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous and active-low. All registered outputs clear immediately: state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, load_data=0, access_err=0, timeout counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE with req_valid=1 and a legal, aligned access:
  - Latch all request fields.
  - Next state BUSY.
- IDLE with req_valid=1 and an illegal code or misaligned address:
  - Misaligned means word with addr[1:0]!=0, or half with addr[0]!=0.
  - No bus activity; next state DONE with access_err=1 and load_data=0.
- stall = req_valid && state!=DONE. stall is combinational, so the request cycle stalls.
- BUSY:
  - bus_req=1; bus_we/addr/be/wdata are held stable from the latched values until ack.
  - On bus_ack: capture the extended bus_rdata into load_data (loads only) and go to DONE.
  - Each cycle without ack increments the counter. When counter==TIMEOUT: drop bus_req, set load_data=0, access_err=1, go to DONE.
- DONE:
  - stall=0, so the core advances at this clock edge.
  - access_err is asserted in DONE only.
  - Always return to IDLE. Back-to-back accesses therefore cost 1 IDLE + >=1 BUSY + 1 DONE cycles.
- req_valid dropping during BUSY: the transaction still completes, since the bus is never abandoned. The result is discarded and the FSM returns to IDLE via DONE.
- Byte enables (o = addr[1:0]):
  - byte: 4'b0001<<o.
  - half: 4'b0011<<{o[1],1'b0}.
  - word: 4'b1111.
  - Loads use bus_be=4'b1111.
- Store data: byte is replicated {4{wdata[7:0]}}; half is {2{wdata[15:0]}}; word passes through.
- Load extract: select byte o or half o[1] from bus_rdata. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- bus_ack outside BUSY is ignored.
- Reset asserted during BUSY: bus_req drops asynchronously and no result is produced.

Decomposition:
- Package lsu_pkg holds:
  - the store-size localparams (SZ_W=2'b00, SZ_B=2'b01, SZ_H=2'b10);
  - the load-adjust localparams (LD_W=3'b000, LD_B=3'b001, LD_H=3'b010, LD_BU=3'b101, LD_HU=3'b110);
  - the state encoding.
- One combinational sub-module, lsu_load_align(rdata, offset, load_adj -> data), for extraction and extension.
- FSM, counter and store lane logic stay in the top module.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack after 2 cycles:
  - required: bus_we=1, be=1111, bus_addr=0x100, wdata=0xDEADBEEF;
  - stall high for 4 cycles (IDLE + 2 BUSY without ack + ack cycle), low in DONE.
- SB addr=0x103, wdata=0x000000A5:
  - required: be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100.
- LB addr=0x102, bus_rdata=0x0080FF11: load_data=0xFFFFFF80.
- Same address with LBU: load_data=0x00000080.
- LH addr=0x102, rdata=0x8001xxxx: load_data=0xFFFF8001.
- LW addr=0x102: no bus_req, access_err pulse in DONE, load_data=0, stall low after 1 cycle.
- Load with ack never arriving: bus_req drops after TIMEOUT=255 BUSY cycles, access_err=1, then IDLE.
- rst_n low mid-BUSY: bus_req=0 immediately, state IDLE; next request proceeds normally.
